// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
package pc_pkg;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_HOLD = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT      = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VECTOR_DEFAULT = 32'h0000_4180;
  localparam int          PC_INC                = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry redirect buffer: keeps a branch/jump target resolved during a fetch stall.
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_target,
  output logic             valid,
  output logic [WIDTH-1:0] target,
  output pc_state_e        state
);

  // Clear wins over load; the parent never asserts both in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= PC_RUN;
    end else if (clear) begin
      state <= PC_RUN;
    end else if (load) begin
      state <= PC_HOLD;
    end
  end

  // Target is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      target <= load_target;
    end
  end

  assign valid = (state == PC_HOLD);

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: next-PC selection, stalled-redirect buffering and EPC.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_RESET_DEFAULT),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(PC_EXC_VECTOR_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_epc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             misalign,
  output logic             redirect_pending
);

  logic             live_redir;
  logic [WIDTH-1:0] live_target;
  logic             trap;
  logic             buf_load;
  logic             buf_clear;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_target;
  pc_state_e        buf_state;
  logic [WIDTH-1:0] pc_next;

  assign live_redir  = jump | br_taken;
  assign live_target = jump ? jump_target : br_target;
  assign trap        = exc_req | eret;

  // Any unstalled edge either consumes the buffer or supersedes it.
  assign buf_load  = !trap && stall && live_redir;
  assign buf_clear = trap || !stall;

  pc_redirect_buf #(
    .WIDTH(WIDTH)
  ) u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_target(live_target),
    .valid      (buf_valid),
    .target     (buf_target),
    .state      (buf_state)
  );

  always_comb begin
    pc_next = pc;
    if (exc_req) begin
      pc_next = EXC_VECTOR;
    end else if (eret) begin
      pc_next = epc;
    end else if (!stall) begin
      if (live_redir) begin
        pc_next = live_target;
      end else if (buf_valid) begin
        pc_next = buf_target;
      end else begin
        pc_next = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      epc <= '0;
    end else if (exc_req) begin
      epc <= exc_epc;
    end
  end

  assign pc_plus4         = pc + WIDTH'(PC_INC);
  assign misalign         = |pc[1:0];
  assign redirect_pending = (buf_state == PC_HOLD);

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus randomized traffic against a reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, jump, exc_req, eret;
  logic [31:0] br_target, jump_target, exc_epc;
  logic [31:0] pc, pc_plus4, epc;
  logic        misalign, redirect_pending;

  logic       reset8, jump8;
  logic [7:0] jump_target8;
  logic [7:0] pc8, pc_plus48, epc8;
  logic       misalign8, redirect_pending8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_epc;
  logic [31:0] pend_q[$];

  always #5 clk = ~clk;

  pc_unit u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target),
    .exc_req(exc_req), .exc_epc(exc_epc), .eret(eret),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .misalign(misalign), .redirect_pending(redirect_pending)
  );

  pc_unit #(.WIDTH(8), .RESET_PC(8'hFC), .EXC_VECTOR(8'h80)) u_dut8 (
    .clk(clk), .reset(reset8), .stall(1'b0),
    .br_taken(1'b0), .br_target(8'h00),
    .jump(jump8), .jump_target(jump_target8),
    .exc_req(1'b0), .exc_epc(8'h00), .eret(1'b0),
    .pc(pc8), .pc_plus4(pc_plus48), .epc(epc8),
    .misalign(misalign8), .redirect_pending(redirect_pending8)
  );

  // Architectural model: PC, EPC and a queue of at most one deferred target.
  task automatic model_edge();
    logic [31:0] tgt;
    if (!reset) begin
      m_pc = 32'h0000_3000; m_epc = 32'h0; pend_q.delete();
    end else if (exc_req) begin
      m_epc = exc_epc; m_pc = 32'h0000_4180; pend_q.delete();
    end else if (eret) begin
      m_pc = m_epc; pend_q.delete();
    end else if (jump || br_taken) begin
      tgt = jump ? jump_target : br_target;
      pend_q.delete();
      if (stall) pend_q.push_back(tgt);
      else m_pc = tgt;
    end else if (!stall) begin
      if (pend_q.size() > 0) m_pc = pend_q.pop_front();
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; jump = 0; exc_req = 0; eret = 0;
    br_target = '0; jump_target = '0; exc_epc = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle_inputs();
    reset = 0; reset8 = 1; jump8 = 0; jump_target8 = 8'h00;
    br_taken = 1; jump = 1; exc_req = 1; stall = 1;
    jump_target = 32'h1234_5678; exc_epc = 32'hDEAD_BEE0;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 32'h3000 || epc !== 32'h0 || redirect_pending !== 1'b0 ||
        misalign !== 1'b0 || pc_plus4 !== 32'h3004) begin
      n_fail++;
      $display("FAIL reset_state pc=%h epc=%h pend=%b mis=%b p4=%h want 3000/0/0/0/3004",
               pc, epc, redirect_pending, misalign, pc_plus4);
    end
    reset = 1;
    exp_pc = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      n_checks++;
      if (pc !== exp_pc || redirect_pending !== 1'b0) begin
        n_fail++;
        $display("FAIL free_run[%0d] pc=%h pend=%b want %h/0", i, pc, redirect_pending, exp_pc);
      end
    end
  endtask

  task automatic test_stalled_branch();
    reset = 0; tick(); reset = 1;
    tick(); tick();
    n_checks++;
    if (pc !== 32'h3008) begin
      n_fail++; $display("FAIL sb_setup pc=%h want 3008", pc);
    end
    stall = 1; br_taken = 1; br_target = 32'h3100;
    tick();
    br_taken = 0; br_target = '0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pc !== 32'h3008 || redirect_pending !== 1'b1) begin
        n_fail++;
        $display("FAIL sb_hold[%0d] pc=%h pend=%b want 3008/1", i, pc, redirect_pending);
      end
      if (i < 2) tick();
    end
    stall = 0;
    tick();
    n_checks++;
    if (pc !== 32'h3100 || redirect_pending !== 1'b0) begin
      n_fail++; $display("FAIL sb_apply pc=%h pend=%b want 3100/0", pc, redirect_pending);
    end
    tick();
    n_checks++;
    if (pc !== 32'h3104) begin
      n_fail++; $display("FAIL sb_after pc=%h want 3104", pc);
    end
  endtask

  task automatic test_exc_eret();
    stall = 1; exc_req = 1; exc_epc = 32'h3010;
    tick();
    exc_req = 0; exc_epc = '0;
    n_checks++;
    if (pc !== 32'h4180 || epc !== 32'h3010) begin
      n_fail++; $display("FAIL exc_entry pc=%h epc=%h want 4180/3010", pc, epc);
    end
    stall = 0; eret = 1;
    tick();
    eret = 0;
    n_checks++;
    if (pc !== 32'h3010 || epc !== 32'h3010) begin
      n_fail++; $display("FAIL eret pc=%h epc=%h want 3010/3010", pc, epc);
    end
  endtask

  task automatic test_priority();
    stall = 1; jump = 1; jump_target = 32'h3300;
    tick();
    n_checks++;
    if (redirect_pending !== 1'b1 || pc !== 32'h3010) begin
      n_fail++; $display("FAIL prio_setup pend=%b pc=%h want 1/3010", redirect_pending, pc);
    end
    exc_req = 1; eret = 1; jump = 1; jump_target = 32'h3200; exc_epc = 32'h3020;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 32'h4180 || epc !== 32'h3020 || redirect_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_exc pc=%h epc=%h pend=%b want 4180/3020/0", pc, epc, redirect_pending);
    end
    tick();
    n_checks++;
    if (pc !== 32'h4184) begin
      n_fail++; $display("FAIL prio_nobuf pc=%h want 4184", pc);
    end
  endtask

  task automatic test_jump_vs_branch();
    jump = 1; jump_target = 32'h3400; br_taken = 1; br_target = 32'h3500;
    tick();
    n_checks++;
    if (pc !== 32'h3400) begin
      n_fail++; $display("FAIL jump_wins pc=%h want 3400", pc);
    end
    stall = 1; jump = 1; jump_target = 32'h3600; br_taken = 0;
    tick();
    jump = 0; br_taken = 1; br_target = 32'h3702;
    tick();
    br_taken = 0; stall = 0;
    tick();
    n_checks++;
    if (pc !== 32'h3702 || misalign !== 1'b1 || redirect_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL overwrite pc=%h mis=%b pend=%b want 3702/1/0", pc, misalign, redirect_pending);
    end
    idle_inputs();
  endtask

  task automatic test_reset_hold();
    stall = 1; br_taken = 1; br_target = 32'h3100;
    tick();
    br_taken = 0;
    reset = 0;
    tick();
    n_checks++;
    if (pc !== 32'h3000 || epc !== 32'h0 || redirect_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold pc=%h epc=%h pend=%b want 3000/0/0", pc, epc, redirect_pending);
    end
    reset = 1; stall = 0;
    tick();
    n_checks++;
    if (pc !== 32'h3004) begin
      n_fail++; $display("FAIL reset_hold_inc1 pc=%h want 3004", pc);
    end
    tick();
    n_checks++;
    if (pc !== 32'h3008 || redirect_pending !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold_inc2 pc=%h pend=%b want 3008/0", pc, redirect_pending);
    end
  endtask

  task automatic test_wrap8();
    reset8 = 0;
    tick();
    reset8 = 1;
    n_checks++;
    if (pc8 !== 8'hFC || pc_plus48 !== 8'h00 || epc8 !== 8'h00) begin
      n_fail++; $display("FAIL w8_reset pc=%h p4=%h epc=%h want fc/00/00", pc8, pc_plus48, epc8);
    end
    tick();
    n_checks++;
    if (pc8 !== 8'h00 || misalign8 !== 1'b0) begin
      n_fail++; $display("FAIL w8_wrap pc=%h mis=%b want 00/0", pc8, misalign8);
    end
    jump8 = 1; jump_target8 = 8'h02;
    tick();
    jump8 = 0;
    n_checks++;
    if (pc8 !== 8'h02 || misalign8 !== 1'b1 || redirect_pending8 !== 1'b0) begin
      n_fail++; $display("FAIL w8_misalign pc=%h mis=%b want 02/1", pc8, misalign8);
    end
    tick();
    n_checks++;
    if (pc8 !== 8'h06 || misalign8 !== 1'b1) begin
      n_fail++; $display("FAIL w8_inc pc=%h mis=%b want 06/1", pc8, misalign8);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 59) != 0);
      stall     = ($urandom_range(0, 2) == 0);
      br_taken  = ($urandom_range(0, 5) == 0);
      jump      = ($urandom_range(0, 7) == 0);
      exc_req   = ($urandom_range(0, 19) == 0);
      eret      = ($urandom_range(0, 15) == 0);
      br_target   = {16'h0000, 4'h5, $urandom_range(0, 4095)} & 32'hFFFF_FFFC;
      jump_target = $urandom();
      if ($urandom_range(0, 3) != 0) jump_target[1:0] = 2'b00;
      exc_epc   = $urandom();
      tick();
      n_checks++;
      if (pc !== m_pc || epc !== m_epc || pc_plus4 !== m_pc + 32'd4 ||
          misalign !== (m_pc[1:0] != 2'b00) || redirect_pending !== (pend_q.size() != 0)) begin
        n_fail++;
        $display("FAIL random[%0d] pc=%h epc=%h p4=%h mis=%b pend=%b want %h/%h/%h/%b/%b",
                 i, pc, epc, pc_plus4, misalign, redirect_pending,
                 m_pc, m_epc, m_pc + 32'd4, (m_pc[1:0] != 2'b00), (pend_q.size() != 0));
      end
    end
    idle_inputs();
    reset = 1;
  endtask

  initial begin
    m_pc = '0; m_epc = '0;
    test_reset();
    test_stalled_branch();
    test_exc_eret();
    test_priority();
    test_jump_vs_branch();
    test_reset_hold();
    test_wrap8();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
